// File: rtl/i2s_dac_sequencer.sv
// I2S frame sequencer for the PCM5102 DAC: BCK/LRCK/DIN generation with a one-entry sample buffer.
// Underrun behaviour: define I2S_UNDERRUN_HOLD_EN to repeat the last frame; otherwise silence is sent.
module i2s_dac_sequencer #(
   parameter int unsigned DIV_HALF = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] in_left,
   input  logic [15:0] in_right,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        i2s_bck,
   output logic        i2s_lrck,
   output logic        i2s_din,
   output logic        i2s_xsmt,
   output logic        underrun,
   output logic        frame_strobe
);

   localparam int unsigned DIV_W   = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam int unsigned SLOT_W  = 5;
   localparam int unsigned FRAME_W = 32;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

   logic [DIV_W-1:0]   div_q,   div_d;
   logic               bck_q,   bck_d;
   logic [SLOT_W-1:0]  slot_q,  slot_d;
   logic               lrck_q,  lrck_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [FRAME_W-1:0] hold_q,  hold_d;
   logic               full_q,  full_d;
   logic               ready_q;
   logic               xsmt_q,  xsmt_d;
   logic               ur_q,    ur_d;
   logic               strobe_q, strobe_d;
`ifdef I2S_UNDERRUN_HOLD_EN
   logic [FRAME_W-1:0] last_q,  last_d;
`endif

   logic               div_term;
   logic               fall;
   logic               load;
   logic [SLOT_W-1:0]  slot_inc;

   assign div_term = (div_q == DIV_LAST);
   assign fall     = div_term && bck_q;
   assign load     = fall && (slot_q == SLOT_W'(0));
   assign slot_inc = slot_q + SLOT_W'(1);

   // Next-state: timing counters, holding register, frame load/shift, mute release
   always_comb begin
      div_d    = div_q;
      bck_d    = bck_q;
      slot_d   = slot_q;
      lrck_d   = lrck_q;
      frame_d  = frame_q;
      hold_d   = hold_q;
      full_d   = full_q;
      xsmt_d   = xsmt_q;
      ur_d     = 1'b0;
      strobe_d = 1'b0;
`ifdef I2S_UNDERRUN_HOLD_EN
      last_d   = last_q;
`endif

      if (in_valid && !full_q) begin
         hold_d = {in_left, in_right};
         full_d = 1'b1;
      end

      if (!en) begin
         div_d   = '0;
         bck_d   = 1'b0;
         slot_d  = '0;
         lrck_d  = 1'b0;
         frame_d = '0;
         xsmt_d  = 1'b0;
      end else begin
         div_d = div_term ? '0 : div_q + DIV_W'(1);
         if (div_term) bck_d = !bck_q;
         if (fall) begin
            slot_d = slot_inc;
            lrck_d = slot_inc[SLOT_W-1];
            if (load) begin
               strobe_d = 1'b1;
               // Bypass: an accept in the load cycle goes straight to the shifter
               if (full_q || in_valid) begin
                  frame_d = full_q ? hold_q : {in_left, in_right};
                  full_d  = 1'b0;
                  xsmt_d  = 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
                  last_d  = full_q ? hold_q : {in_left, in_right};
`endif
               end else begin
                  ur_d = 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
                  frame_d = last_q;
`else
                  frame_d = '0;
`endif
               end
            end else begin
               frame_d = {frame_q[FRAME_W-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q    <= '0;
         bck_q    <= 1'b0;
         slot_q   <= '0;
         lrck_q   <= 1'b0;
         frame_q  <= '0;
         hold_q   <= '0;
         full_q   <= 1'b0;
         ready_q  <= 1'b1;
         xsmt_q   <= 1'b0;
         ur_q     <= 1'b0;
         strobe_q <= 1'b0;
`ifdef I2S_UNDERRUN_HOLD_EN
         last_q   <= '0;
`endif
      end else begin
         div_q    <= div_d;
         bck_q    <= bck_d;
         slot_q   <= slot_d;
         lrck_q   <= lrck_d;
         frame_q  <= frame_d;
         hold_q   <= hold_d;
         full_q   <= full_d;
         ready_q  <= !full_d;
         xsmt_q   <= xsmt_d;
         ur_q     <= ur_d;
         strobe_q <= strobe_d;
`ifdef I2S_UNDERRUN_HOLD_EN
         last_q   <= last_d;
`endif
      end
   end

   assign in_ready     = ready_q;
   assign i2s_bck      = bck_q;
   assign i2s_lrck     = lrck_q;
   assign i2s_din      = frame_q[FRAME_W-1];
   assign i2s_xsmt     = xsmt_q;
   assign underrun     = ur_q;
   assign frame_strobe = strobe_q;

endmodule
